// File: rtl/lfsr_rng_pkg.sv
// lfsr_rng_pkg: maximal-length Galois tap masks, default seed and the shared step function
package lfsr_rng_pkg;
  localparam int MAX_W = 64;
  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [31:0] TAPS_32 = 32'h8020_0003;
  localparam logic [63:0] TAPS_64 = 64'hD800_0000_0000_0000;
  localparam logic [31:0] SEED_DEFAULT = 32'hACE1_ACE1;
  // Operands are zero-extended to MAX_W, so the right shift never pulls in bits above the width
  function automatic logic [MAX_W-1:0] lfsr_step(input logic [MAX_W-1:0] s, input logic [MAX_W-1:0] taps);
    return (s >> 1) ^ (s[0] ? taps : '0);
  endfunction
endpackage

// File: rtl/lfsr_rng_core.sv
// lfsr_rng_core: Galois LFSR state register with load priority over advance
module lfsr_rng_core
  import lfsr_rng_pkg::*;
#(
  parameter int              WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(TAPS_32),
  parameter logic [WIDTH-1:0] SEED = WIDTH'(SEED_DEFAULT)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             adv,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] next
);
  logic [WIDTH-1:0] state;
  assign next = WIDTH'(lfsr_step(MAX_W'(state), MAX_W'(TAPS)));
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= SEED;
    else if (load) state <= load_value;
    else if (adv) state <= next;
endmodule

// File: rtl/lfsr_rng.sv
// lfsr_rng: LFSR random word source with reseed, multi-step words and valid/ready backpressure
module lfsr_rng
  import lfsr_rng_pkg::*;
#(
  parameter int              WIDTH         = 32,
  parameter logic [WIDTH-1:0] TAPS          = WIDTH'(TAPS_32),
  parameter logic [WIDTH-1:0] SEED          = WIDTH'(SEED_DEFAULT),
  parameter int              STEPS_PER_OUT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             seed_valid,
  input  logic [WIDTH-1:0] seed_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] randNum,
  output logic             lockup,
  output logic [15:0]      word_count
);
  localparam int CW = STEPS_PER_OUT > 1 ? $clog2(STEPS_PER_OUT) : 1;
  if (WIDTH < 8 || WIDTH > 64) begin : g_bad_width
    $error("lfsr_rng: WIDTH must be 8..64");
  end
  if (!TAPS[WIDTH-1]) begin : g_bad_taps
    $error("lfsr_rng: TAPS must have bit WIDTH-1 set");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_rng: SEED must be nonzero");
  end
  if (STEPS_PER_OUT < 1 || STEPS_PER_OUT > WIDTH) begin : g_bad_steps
    $error("lfsr_rng: STEPS_PER_OUT must be 1..WIDTH");
  end
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] next;
  logic             last, hs, adv, zero_seed;
  assign last      = cnt == CW'(STEPS_PER_OUT - 1);
  assign hs        = out_valid && out_ready;
  assign zero_seed = seed_data == '0;
  // The final step stalls while an unconsumed word is still held
  assign adv       = enable && !seed_valid && (!last || !out_valid || out_ready);
  lfsr_rng_core #(.WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED)) u_core (
    .clock      (clock),
    .reset      (reset),
    .adv        (adv),
    .load       (seed_valid),
    .load_value (zero_seed ? SEED : seed_data),
    .next       (next)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cnt        <= '0;
      out_valid  <= 1'b0;
      randNum    <= '0;
      lockup     <= 1'b0;
      word_count <= '0;
    end else if (seed_valid) begin
      cnt        <= '0;
      out_valid  <= 1'b0;
      word_count <= '0;
      lockup     <= zero_seed;
    end else begin
      lockup    <= 1'b0;
      if (hs) word_count <= word_count + 16'd1;
      if (adv) cnt <= last ? '0 : cnt + CW'(1);
      if (adv && last) randNum <= next;
      out_valid <= (adv && last) || (out_valid && !out_ready);
    end
endmodule

// File: tb/tb_lfsr_rng.sv
// tb_lfsr_rng: checks a 1-step and a 3-step instance against a single-slot word model
module tb_lfsr_rng;
  localparam logic [31:0] TAPS = 32'h8020_0003;
  localparam logic [31:0] SEED = 32'hACE1_ACE1;
  logic        clock = 1'b0, reset = 1'b1, enable = 1'b0, seed_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] seed_data = '0;
  logic        v1, l1, v3, l3;
  logic [31:0] r1, r3;
  logic [15:0] w1, w3;
  int          checks = 0, failures = 0;
  logic [31:0] m_lfsr[2], m_word[2];
  logic        m_valid[2], m_lock[2];
  int          m_cnt[2], m_wc[2];
  int          steps[2] = '{1, 3};
  always #5 clock = ~clock;
  lfsr_rng dut1 (
    .clock(clock), .reset(reset), .enable(enable), .seed_valid(seed_valid), .seed_data(seed_data),
    .out_ready(out_ready), .out_valid(v1), .randNum(r1), .lockup(l1), .word_count(w1)
  );
  lfsr_rng #(.STEPS_PER_OUT(3)) dut3 (
    .clock(clock), .reset(reset), .enable(enable), .seed_valid(seed_valid), .seed_data(seed_data),
    .out_ready(out_ready), .out_valid(v3), .randNum(r3), .lockup(l3), .word_count(w3)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 32'h0);
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_lfsr[i] = SEED; m_word[i] = '0; m_valid[i] = 1'b0; m_lock[i] = 1'b0; m_cnt[i] = 0; m_wc[i] = 0;
    end
  endtask
  // Consume the held word first, then a final step may only fill an empty slot
  task automatic model_clock();
    for (int i = 0; i < 2; i++) begin
      if (seed_valid) begin
        m_lfsr[i] = (seed_data == 0) ? SEED : seed_data;
        m_lock[i] = (seed_data == 0);
        m_cnt[i] = 0; m_valid[i] = 1'b0; m_wc[i] = 0;
      end else begin
        m_lock[i] = 1'b0;
        if (m_valid[i] && out_ready) begin
          m_valid[i] = 1'b0;
          m_wc[i] = (m_wc[i] + 1) % 65536;
        end
        if (enable) begin
          if (m_cnt[i] < steps[i] - 1) begin
            m_lfsr[i] = step(m_lfsr[i]); m_cnt[i]++;
          end else if (!m_valid[i]) begin
            m_lfsr[i] = step(m_lfsr[i]); m_cnt[i] = 0; m_word[i] = m_lfsr[i]; m_valid[i] = 1'b1;
          end
        end
      end
    end
  endtask
  task automatic compare_all();
    check("s1_valid", 64'(v1), 64'(m_valid[0]));
    check("s1_rand", 64'(r1), 64'(m_word[0]));
    check("s1_lockup", 64'(l1), 64'(m_lock[0]));
    check("s1_count", 64'(w1), 64'(m_wc[0]));
    check("s3_valid", 64'(v3), 64'(m_valid[1]));
    check("s3_rand", 64'(r3), 64'(m_word[1]));
    check("s3_lockup", 64'(l3), 64'(m_lock[1]));
    check("s3_count", 64'(w3), 64'(m_wc[1]));
  endtask
  task automatic cycle();
    @(posedge clock);
    model_clock();
    #1 compare_all();
  endtask
  initial begin
    model_reset();
    #2 compare_all();
    @(negedge clock);
    reset = 1'b0; enable = 1'b1; out_ready = 1'b1;
    cycle();
    check("t1_first_valid", 64'(v1), 64'd1);
    check("t1_first_word", 64'(r1), 64'hD650D673);
    repeat (3) cycle();
    seed_valid = 1'b1; seed_data = 32'h1;
    cycle();
    seed_valid = 1'b0;
    cycle();
    check("t2_w0", 64'(r1), 64'h80200003);
    check("t2_wc0", 64'(w1), 64'd0);
    cycle();
    check("t2_w1", 64'(r1), 64'hC0300002);
    cycle();
    check("t2_w2", 64'(r1), 64'h60180001);
    check("t5_s3_first", 64'(r3), 64'h60180001);
    check("t5_s3_valid", 64'(v3), 64'd1);
    cycle();
    check("t2_wc3", 64'(w1), 64'd3);
    seed_valid = 1'b1; seed_data = 32'h0;
    cycle();
    check("t3_lockup_on", 64'(l1), 64'd1);
    seed_valid = 1'b0;
    cycle();
    check("t3_lockup_off", 64'(l1), 64'd0);
    check("t3_word", 64'(r1), 64'hD650D673);
    seed_valid = 1'b1; seed_data = 32'h1; out_ready = 1'b0;
    cycle();
    seed_valid = 1'b0;
    cycle();
    check("t4_held_first", 64'(r1), 64'h80200003);
    repeat (5) cycle();
    check("t4_held_after", 64'(r1), 64'h80200003);
    check("t4_still_valid", 64'(v1), 64'd1);
    out_ready = 1'b1;
    cycle();
    check("t4_released", 64'(r1), 64'hC0300002);
    seed_valid = 1'b1; seed_data = 32'h1;
    cycle();
    seed_valid = 1'b0;
    cycle();
    enable = 1'b0;
    repeat (2) cycle();
    enable = 1'b1;
    cycle();
    check("t5_delay_not_yet", 64'(v3), 64'd0);
    cycle();
    check("t5_delay_valid", 64'(v3), 64'd1);
    check("t5_delay_word", 64'(r3), 64'h60180001);
    seed_valid = 1'b1; seed_data = 32'h1234_5678;
    cycle();
    seed_valid = 1'b0;
    check("t6_reseed_valid", 64'(v1), 64'd0);
    check("t6_reseed_count", 64'(w1), 64'd0);
    out_ready = 1'b0;
    repeat (4) cycle();
    #3 reset = 1'b1;
    #1;
    model_reset();
    check("t6_async_valid", 64'(v1), 64'd0);
    check("t6_async_rand", 64'(r1), 64'd0);
    compare_all();
    @(negedge clock);
    reset = 1'b0;
    for (int n = 0; n < 600; n++) begin
      enable     = ($urandom_range(3) != 0);
      out_ready  = ($urandom_range(4) > 1);
      seed_valid = ($urandom_range(19) == 0);
      seed_data  = ($urandom_range(3) == 0) ? 32'h0 : 32'($urandom);
      cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lfsr_rng.md
Name: lfsr_rng

Overview:
Parametrised Galois LFSR pseudo-random generator with runtime reseeding, a configurable number of shifts per output word, and a valid/ready output handshake with backpressure. It generalises the fixed 32-bit free-running `lsfr` block. Software-visible random sources and stimulus generators in the CPU datapath consume it through the handshake.

Parameters:
WIDTH, 32, LFSR and output word width; legal range 8..64.
TAPS, 32'h8020_0003, Galois feedback mask for x^32+x^22+x^2+x+1; bit WIDTH-1 must be set (elaboration error otherwise).
SEED, 32'hACE1_ACE1, reset and fallback state; must be nonzero (elaboration error otherwise).
STEPS_PER_OUT, 1, LFSR shifts per emitted word; legal range 1..WIDTH.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
enable  in  1  permits LFSR advance this cycle
seed_valid  in  1  load seed_data this cycle
seed_data  in  WIDTH  new LFSR state
out_ready  in  1  consumer accepts randNum
out_valid  out  1  randNum holds an unconsumed word
randNum  out  WIDTH  registered output word
lockup  out  1  one-cycle pulse: zero seed replaced by SEED
word_count  out  16  count of handshaken words

Behaviour:
- Reset (asynchronous, active-high): lfsr=SEED, cnt=0, out_valid=0, randNum=0, lockup=0, word_count=0.
- Step function: next = lfsr[0] ? (lfsr>>1)^TAPS : (lfsr>>1), WIDTH bits.
- accept = !out_valid || out_ready.
- adv = enable && !seed_valid && (cnt != STEPS_PER_OUT-1 || accept).
- When adv:
  - lfsr <= next.
  - If cnt == STEPS_PER_OUT-1: cnt <= 0, randNum <= next, out_valid <= 1.
  - Otherwise: cnt <= cnt+1.
- Backpressure: at the final step with out_valid=1 and out_ready=0, the LFSR and cnt freeze. No word is dropped or overwritten. randNum stays stable while out_valid=1 and out_ready=0.
- Handshake: out_valid && out_ready. On a handshake without a same-cycle final-step load, out_valid <= 0. With STEPS_PER_OUT=1, enable=1 and out_ready=1, a new word is emitted every cycle.
- word_count increments on each handshake and wraps 16'hFFFF -> 0.
- Latency: after reset release or reseed, the first out_valid rises at the clock edge of the STEPS_PER_OUT-th enabled cycle.
- Reseed (seed_valid=1) takes priority over everything:
  - lfsr <= seed_data, or SEED if seed_data == 0 (and lockup=1 for that cycle).
  - cnt <= 0, out_valid <= 0, word_count <= 0.
  - A same-cycle handshake word is discarded and not counted.
- lockup is 0 in every other cycle.
- A nonzero state never reaches zero under the step function, so no other zero-state handling exists.
- enable=0: lfsr and cnt hold. The output handshake still operates.
- Reset asserted mid-operation returns all state to reset values immediately, with no wait for a clock edge.

Decomposition:
- Package lfsr_rng_pkg holds:
  - maximal-length tap constants for widths 8, 16, 32, 64;
  - the default SEED constant;
  - a step function parametrised by width and taps.
- Sub-module lfsr_rng_core: state register plus step logic, with an adv/load/load_value interface.
- The top level holds cnt, the output register, the handshake and word_count.

Test Plan:
1. Reset, enable=1, out_ready=1, defaults -> first word 0xD650D673, out_valid=1 one cycle after reset release; a new word every cycle.
2. seed_valid with seed_data=0x00000001, then enable -> words 0x80200003, 0xC0300002, 0x60180001; word_count 0 -> 3.
3. seed_data=0 -> lockup pulses exactly one cycle; next word 0xD650D673.
4. Seed 1, hold out_ready=0 for 5 cycles -> randNum stays 0x80200003, LFSR frozen. Release -> 0xC0300002 next, no word skipped.
5. STEPS_PER_OUT=3, seed 1 -> first word 0x60180001 after 3 enabled cycles; enable deasserted for 2 cycles mid-count delays it by exactly 2 cycles.
6. Reseed in the same cycle as a handshake -> out_valid=0 next cycle, word_count=0. Asynchronous reset mid-stall -> outputs at reset values before the next edge.
